// File: rtl/parking_controller.sv
// Parking-lot controller: tracks NUM_SLOTS spots, assigns the lowest free
// spot on entry, frees a named spot on exit, times the gate-open window and
// reports free capacity / full status. Every output comes straight from a flop.
module parking_controller #(
    parameter int NUM_SLOTS   = 8,
    parameter int GATE_CYCLES = 2,
    localparam int SW = $clog2(NUM_SLOTS),
    localparam int CW = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SW-1:0]        exit_slot,
    output logic                 entry_ack,
    output logic                 entry_rej,
    output logic                 exit_ack,
    output logic                 exit_err,
    output logic                 is_open,
    output logic                 is_full,
    output logic [NUM_SLOTS-1:0] spots,
    output logic [CW-1:0]        capacity,
    output logic [SW-1:0]        location
);

    // Gate counter holds GATE_CYCLES-1 down to 0; keep at least one bit.
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [NUM_SLOTS-1:0] spots_q,     spots_d;
    logic [CW-1:0]        capacity_q,  capacity_d;
    logic [SW-1:0]        location_q,  location_d;
    logic [GW-1:0]        gate_cnt_q,  gate_cnt_d;
    logic                 is_open_q,   is_open_d;
    logic                 is_full_q,   is_full_d;
    logic                 entry_ack_q, entry_ack_d;
    logic                 entry_rej_q, entry_rej_d;
    logic                 exit_ack_q,  exit_ack_d;
    logic                 exit_err_q,  exit_err_d;

    logic [SW-1:0]        free_idx;
    logic                 exit_in_range;
    logic                 exit_hit;

    // Lowest-index free spot: scan downward so the last hit is the lowest.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!spots_q[i]) begin
                free_idx = SW'(i);
            end
        end
    end

    // An exit is valid only for an in-range, currently occupied spot.
    always_comb begin
        exit_in_range = (int'(exit_slot) < NUM_SLOTS);
        exit_hit      = exit_in_range && spots_q[exit_slot];
    end

    // Next-state logic: exit wins over entry; GATE and HOLD ignore requests.
    always_comb begin
        state_d     = state_q;
        spots_d     = spots_q;
        capacity_d  = capacity_q;
        location_d  = location_q;
        gate_cnt_d  = gate_cnt_q;
        is_open_d   = is_open_q;
        entry_ack_d = 1'b0;
        entry_rej_d = 1'b0;
        exit_ack_d  = 1'b0;
        exit_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (exit_req) begin
                    if (exit_hit) begin
                        spots_d[exit_slot] = 1'b0;
                        capacity_d         = capacity_q + CW'(1);
                        exit_ack_d         = 1'b1;
                        is_open_d          = 1'b1;
                        gate_cnt_d         = GW'(GATE_CYCLES - 1);
                        state_d            = ST_GATE;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (capacity_q != '0) begin
                        spots_d[free_idx] = 1'b1;
                        location_d        = free_idx;
                        capacity_d        = capacity_q - CW'(1);
                        entry_ack_d       = 1'b1;
                        is_open_d         = 1'b1;
                        gate_cnt_d        = GW'(GATE_CYCLES - 1);
                        state_d           = ST_GATE;
                    end else begin
                        entry_rej_d = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                // The accept edge already counted as the first open cycle.
                if (gate_cnt_q == '0) begin
                    is_open_d = 1'b0;
                    state_d   = ST_HOLD;
                end else begin
                    gate_cnt_d = gate_cnt_q - GW'(1);
                end
            end
            ST_HOLD: begin
                // One closed cycle so the requester can drop its level.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                is_open_d = 1'b0;
            end
        endcase

        is_full_d = (capacity_d == '0);
    end

    // State and registered outputs; async reset clears everything incl. the gate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            spots_q     <= '0;
            capacity_q  <= CW'(NUM_SLOTS);
            location_q  <= '0;
            gate_cnt_q  <= '0;
            is_open_q   <= 1'b0;
            is_full_q   <= 1'b0;
            entry_ack_q <= 1'b0;
            entry_rej_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            exit_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            spots_q     <= spots_d;
            capacity_q  <= capacity_d;
            location_q  <= location_d;
            gate_cnt_q  <= gate_cnt_d;
            is_open_q   <= is_open_d;
            is_full_q   <= is_full_d;
            entry_ack_q <= entry_ack_d;
            entry_rej_q <= entry_rej_d;
            exit_ack_q  <= exit_ack_d;
            exit_err_q  <= exit_err_d;
        end
    end

    assign entry_ack = entry_ack_q;
    assign entry_rej = entry_rej_q;
    assign exit_ack  = exit_ack_q;
    assign exit_err  = exit_err_q;
    assign is_open   = is_open_q;
    assign is_full   = is_full_q;
    assign spots     = spots_q;
    assign capacity  = capacity_q;
    assign location  = location_q;

endmodule
